// File: rtl/sonar_filter.sv
// sonar_filter: median-of-three smoothing of sr04 range samples, near-obstacle
// detection with a sticky interrupt, and a no-sample watchdog for a dead sensor.
// Stage 1 accepts a sample into the three-deep history; stage 2 (one edge later)
// publishes the filtered distance and the near flag together.
module sonar_filter #(
    parameter int DW      = 8,
    parameter int TMO_W   = 22,
    parameter int TIMEOUT = 3_000_000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [DW-1:0] dist_in,
    input  logic          dist_valid,
    input  logic [DW-1:0] thresh,
    input  logic          irq_clr,
    output logic [DW-1:0] filt_dist,
    output logic          filt_valid,
    output logic          near,
    output logic          stale,
    output logic          irq
);

    // Watchdog limits: the counter parks at TMO_MAX; reaching it from TMO_LAST is
    // the single edge on which the history is flushed.
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [TMO_W-1:0] TMO_ZERO = TMO_W'(0);
    localparam logic [DW-1:0]    D_ZERO   = {DW{1'b0}};
    localparam logic [1:0]       FILL_MAX = 2'd3;

    // Unsigned minimum of two samples.
    function automatic logic [DW-1:0] min2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // Unsigned maximum of two samples.
    function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a < b) ? b : a;
    endfunction

    // Median of three; a duplicated value always wins because it survives
    // both the min and the max stage.
    function automatic logic [DW-1:0] med3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    // Registered state.
    logic [DW-1:0]    h0_r, h1_r, h2_r;
    logic [1:0]       fill_r;
    logic [TMO_W-1:0] cnt_r;
    logic             s2_r;

    // Next-state values.
    logic [DW-1:0]    h0_s, h1_s, h2_s;
    logic [1:0]       fill_s;
    logic [TMO_W-1:0] cnt_s;
    logic             s2_s;
    logic             stale_s;
    logic [DW-1:0]    filt_dist_s;
    logic             filt_valid_s;
    logic             near_s;
    logic             irq_s;

    // Helpers.
    logic             accept_s;
    logic             s2_go_s;
    logic [DW-1:0]    filt_new_s;
    logic             near_new_s;
    logic             near_rise_s;

    assign accept_s = dist_valid & en;
    assign s2_go_s  = s2_r & en;

    // Stage-2 filter value chosen by how many valid history entries exist.
    always_comb begin
        filt_new_s = h0_r;
        case (fill_r)
            2'd1:    filt_new_s = h0_r;
            2'd2:    filt_new_s = min2(h0_r, h1_r);
            2'd3:    filt_new_s = med3(h0_r, h1_r, h2_r);
            default: filt_new_s = h0_r;
        endcase
    end

    assign near_new_s  = (thresh != D_ZERO) && (filt_new_s < thresh);
    assign near_rise_s = s2_go_s & near_new_s & ~near;

    // History shift, fill level and watchdog; en low or an accepted sample
    // takes precedence over the timeout.
    always_comb begin
        h0_s    = h0_r;
        h1_s    = h1_r;
        h2_s    = h2_r;
        fill_s  = fill_r;
        cnt_s   = cnt_r;
        stale_s = stale;
        s2_s    = accept_s;
        if (!en) begin
            fill_s  = 2'd0;
            cnt_s   = TMO_ZERO;
            stale_s = 1'b0;
        end else if (accept_s) begin
            h2_s    = h1_r;
            h1_s    = h0_r;
            h0_s    = dist_in;
            fill_s  = (fill_r == FILL_MAX) ? FILL_MAX : fill_r + 2'd1;
            cnt_s   = TMO_ZERO;
            stale_s = 1'b0;
        end else if (cnt_r == TMO_MAX) begin
            cnt_s   = TMO_MAX;
            stale_s = 1'b1;
        end else if (cnt_r == TMO_LAST) begin
            cnt_s   = TMO_MAX;
            stale_s = 1'b1;
            fill_s  = 2'd0;
        end else begin
            cnt_s   = cnt_r + TMO_ONE;
        end
    end

    // Stage-2 outputs: update on a live stage-2 op, otherwise hold; irq set beats clear.
    always_comb begin
        filt_valid_s = s2_go_s;
        filt_dist_s  = filt_dist;
        near_s       = near;
        if (s2_go_s) begin
            filt_dist_s = filt_new_s;
            near_s      = near_new_s;
        end else begin
            filt_dist_s = filt_dist;
            near_s      = near;
        end
        if (near_rise_s) begin
            irq_s = 1'b1;
        end else if (irq_clr) begin
            irq_s = 1'b0;
        end else begin
            irq_s = irq;
        end
    end

    // State register with synchronous reset overriding any pending operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            h0_r       <= D_ZERO;
            h1_r       <= D_ZERO;
            h2_r       <= D_ZERO;
            fill_r     <= 2'd0;
            cnt_r      <= TMO_ZERO;
            s2_r       <= 1'b0;
            stale      <= 1'b0;
            filt_dist  <= D_ZERO;
            filt_valid <= 1'b0;
            near       <= 1'b0;
            irq        <= 1'b0;
        end else begin
            h0_r       <= h0_s;
            h1_r       <= h1_s;
            h2_r       <= h2_s;
            fill_r     <= fill_s;
            cnt_r      <= cnt_s;
            s2_r       <= s2_s;
            stale      <= stale_s;
            filt_dist  <= filt_dist_s;
            filt_valid <= filt_valid_s;
            near       <= near_s;
            irq        <= irq_s;
        end
    end

endmodule

// File: tb/tb_sonar_filter.sv
// Directed scoreboard bench for sonar_filter: stimulus pushes hand-computed
// expectations, a negedge monitor pops them whenever filt_valid is seen.
module tb_sonar_filter;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [7:0] dist_in;
    logic       dist_valid;
    logic [7:0] thresh;
    logic       irq_clr;
    logic [7:0] filt_dist;
    logic       filt_valid;
    logic       near;
    logic       stale;
    logic       irq;

    sonar_filter #(.DW(8), .TMO_W(22), .TIMEOUT(100)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .dist_in    (dist_in),
        .dist_valid (dist_valid),
        .thresh     (thresh),
        .irq_clr    (irq_clr),
        .filt_dist  (filt_dist),
        .filt_valid (filt_valid),
        .near       (near),
        .stale      (stale),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       n;
        int         due;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every filt_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (filt_valid) begin
            if (q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_filt_valid: got pulse with filt_dist=%0d, expected none (cycle %0d)",
                         filt_dist, cyc);
            end else begin
                mon_e = q.pop_front();
                chk("filt_dist", int'(filt_dist), int'(mon_e.d));
                chk("near", int'(near), int'(mon_e.n));
                chk("latency_cycle", cyc, mon_e.due);
            end
        end
    end

    // One-cycle sample; the accept edge is the posedge inside this task.
    task automatic send(input logic [7:0] v, input logic push, input logic [7:0] ed, input logic en_near);
        @(negedge clk);
        dist_in    = v;
        dist_valid = 1'b1;
        @(posedge clk);
        #1;
        dist_valid = 1'b0;
        if (push) q.push_back('{d: ed, n: en_near, due: cyc + 1});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic flush();
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        en = 1'b1;
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        irq_clr = 1'b1;
        @(posedge clk);
        #1;
        irq_clr = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; dist_in = 8'd0; dist_valid = 1'b0;
        thresh = 8'd0; irq_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_filt_dist", int'(filt_dist), 0);
        chk("rst_filt_valid", int'(filt_valid), 0);
        chk("rst_near", int'(near), 0);
        chk("rst_stale", int'(stale), 0);
        chk("rst_irq", int'(irq), 0);

        // Fill sequence, 10 cycles apart.
        en = 1'b1;
        send(8'd40, 1'b1, 8'd40, 1'b0); idle(9);
        send(8'd30, 1'b1, 8'd30, 1'b0); idle(9);
        send(8'd50, 1'b1, 8'd40, 1'b0); idle(3);

        // Outlier rejection, back-to-back.
        flush();
        send(8'd10,  1'b1, 8'd10, 1'b0);
        send(8'd200, 1'b1, 8'd10, 1'b0);
        send(8'd12,  1'b1, 8'd12, 1'b0);
        send(8'd11,  1'b1, 8'd12, 1'b0);
        idle(3);

        // Near / irq.
        flush();
        thresh = 8'd20;
        send(8'd25, 1'b1, 8'd25, 1'b0); idle(3);
        chk("irq_before_near", int'(irq), 0);
        send(8'd15, 1'b1, 8'd15, 1'b1); idle(1);
        chk("irq_set_on_near_rise", int'(irq), 1);
        send(8'd15, 1'b1, 8'd15, 1'b1); idle(2);
        clr_pulse();
        chk("irq_cleared", int'(irq), 0);
        flush();
        send(8'd25, 1'b1, 8'd25, 1'b0); idle(3);
        send(8'd15, 1'b1, 8'd15, 1'b1);
        irq_clr = 1'b1;
        @(posedge clk);
        #1;
        irq_clr = 1'b0;
        chk("irq_set_beats_clr", int'(irq), 1);
        idle(2);
        clr_pulse();
        chk("irq_clr_alone", int'(irq), 0);
        send(8'd15, 1'b1, 8'd15, 1'b1); idle(3);
        chk("irq_no_reset_while_near", int'(irq), 0);

        // Timeout.
        flush();
        thresh = 8'd0;
        send(8'd40, 1'b1, 8'd40, 1'b0); idle(4);
        send(8'd40, 1'b1, 8'd40, 1'b0);
        repeat (99) @(posedge clk);
        #1;
        chk("stale_not_early", int'(stale), 0);
        @(posedge clk);
        #1;
        chk("stale_at_timeout", int'(stale), 1);
        chk("filt_dist_holds", int'(filt_dist), 40);
        idle(5);
        chk("stale_stays", int'(stale), 1);
        send(8'd70, 1'b1, 8'd70, 1'b0);
        chk("stale_clears_on_accept", int'(stale), 0);
        idle(3);

        // en drop: in-flight op cancelled, pulses ignored, history flushed.
        send(8'd99, 1'b0, 8'd0, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            dist_valid = (i % 2 == 0);
            dist_in    = 8'd5;
        end
        @(negedge clk);
        dist_valid = 1'b0;
        chk("stale_en_low", int'(stale), 0);
        chk("near_holds_en_low", int'(near), 0);
        thresh = 8'd50;
        en = 1'b1;
        send(8'd33, 1'b1, 8'd33, 1'b1); idle(2);
        chk("irq_after_reenable", int'(irq), 1);

        // Reset mid-pipeline.
        send(8'd60, 1'b0, 8'd0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midrst_filt_dist", int'(filt_dist), 0);
        chk("midrst_filt_valid", int'(filt_valid), 0);
        chk("midrst_near", int'(near), 0);
        chk("midrst_stale", int'(stale), 0);
        chk("midrst_irq", int'(irq), 0);
        idle(4);

        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sonar_filter.md
Name: sonar_filter

Overview:
Downstream consumer of the sr04 ranging block. Takes each raw dist/valid sample and runs it through a 3-tap median filter to reject single-ping outliers. Flags obstacles closer than a programmable threshold with a latched interrupt. Detects a dead or disconnected sensor with a no-sample timeout. Outputs feed the peripheral register interface.

Parameters:
DW, 8, sample width; matches the sr04 dist output.
TMO_W, 22, width of the timeout counter.
TIMEOUT, 3_000_000, clk cycles with no accepted sample before stale asserts (60 ms at 50 MHz).

Ports:
clk  input  1  system clock, 50 MHz
reset  input  1  synchronous, active-high
en  input  1  filter enable; low flushes state
dist_in  input  DW  raw sample from sr04 dist
dist_valid  input  1  one-cycle strobe from sr04 valid
thresh  input  DW  near threshold; 0 disables near detection
irq_clr  input  1  one-cycle strobe; clears irq
filt_dist  output  DW  filtered distance, held between updates
filt_valid  output  1  one-cycle strobe on each filt_dist update
near  output  1  filt_dist < thresh, registered with filt_dist
stale  output  1  no sample for TIMEOUT cycles
irq  output  1  sticky; set on near rising edge

Behaviour:
- Reset: all outputs are 0. History h0/h1/h2 = 0, fill = 0, timeout counter = 0.
- Sample acceptance: a sample is accepted when dist_valid=1 and en=1 on a clk edge.
  - h2<=h1, h1<=h0, h0<=dist_in.
  - fill saturates at 3.
- Stage 2: on the clk edge after acceptance, filt_dist is computed from the history:
  - fill=1: h0.
  - fill=2: min(h0,h1), the conservative nearer value.
  - fill=3: median(h0,h1,h2), unsigned compare; ties resolve to the duplicated value.
- Latency and throughput:
  - Sample accepted at edge N gives filt_dist updated and filt_valid=1 during the cycle after edge N+1.
  - Fully pipelined: back-to-back dist_valid on consecutive cycles is accepted and produces consecutive filt_valid pulses.
- near is updated only on the stage-2 edge: near <= (thresh!=0) && (new filt_dist < thresh). It holds otherwise.
- irq:
  - Sets on the edge where near goes 0->1.
  - irq_clr clears it.
  - If a set and irq_clr land on the same edge, set wins.
  - irq is not affected by en.
- Timeout:
  - The counter increments each cycle while en=1 and no sample is accepted, and clears on accepted samples.
  - When the counter reaches TIMEOUT:
    - stale<=1 and fill<=0 (history flushed).
    - The counter holds at TIMEOUT.
    - filt_dist and near hold.
  - The next accepted sample clears stale on its acceptance edge and restarts filling at fill=1.
- en=0:
  - fill, the timeout counter and stale are cleared; filt_valid=0.
  - dist_valid is ignored; a stage-2 op in flight is cancelled.
  - filt_dist, near and irq hold.
- Sample plus timeout on the same edge: the sample wins. The counter clears and stale stays/goes 0.
- Reset mid-operation: takes effect on the next edge and overrides everything. There is no filt_valid after reset even if stage 2 was pending.
- All state uses one clock domain. dist_valid and dist_in are already synchronous from sr04.

Test Plan:
- Fill sequence, en=1, thresh=0: samples 40, 30, 50 spaced 10 cycles apart -> filt_dist 40, 30, 40, each filt_valid exactly 2 cycles after dist_valid; near stays 0.
- Outlier rejection: samples 10, 200, 12, then 11 back-to-back -> filt_dist 10, 10, 12, 12 on four consecutive filt_valid pulses.
- Near/irq, thresh=20: samples 25, 15, 15 -> near 0,1,1 and irq set once. Pulse irq_clr on the same edge near would rise in a repeat run -> irq=1. Pulse irq_clr alone later -> irq=0; a further sample 15 does not re-set irq.
- Timeout, TIMEOUT=100: samples 40, 40, then none -> stale=1 exactly 100 cycles after the last acceptance and filt_dist holds 40. Sample 70 -> stale=0 on acceptance, filt_dist=70 (fill restarted).
- en drop: en=0 for 5 cycles with dist_valid pulsing -> no filt_valid, counter stays 0. Re-enable with sample 33 -> filt_dist=33.
- Reset mid-pipeline: assert reset the cycle after dist_valid -> no filt_valid; all outputs 0 next cycle.
